// File: rtl/snn_pkg.sv
// Shared definitions for the SNN datapath: FC2 fixed-point format defaults and
// the state encoding of the output decoder.
package snn_pkg;

    localparam int FC2_WIDTH = 24;
    localparam int FC2_FRAC  = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } dec_state_t;

endpackage

// File: rtl/fc2_output_decoder.sv
// Accumulates FC2 outputs over all timesteps of a frame, then scans the
// accumulators one per cycle to pick the winning class (ties go to the lowest index).
module fc2_output_decoder
    import snn_pkg::*;
#(
    parameter int WIDTH     = FC2_WIDTH,
    parameter int FRAC      = FC2_FRAC,
    parameter int NODES     = 10,
    parameter int TIMESTEPS = 8
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        in_valid,
    input  logic signed [WIDTH-1:0]                     fc_in [0:NODES-1],
    output logic                                        busy,
    output logic                                        done,
    output logic [$clog2(NODES)-1:0]                    class_id,
    output logic signed [WIDTH+$clog2(TIMESTEPS)-1:0]   class_score
);

    localparam int ACC_W  = WIDTH + $clog2(TIMESTEPS);
    localparam int IDX_W  = $clog2(NODES);
    localparam int STEP_W = $clog2(TIMESTEPS + 1);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(TIMESTEPS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NODES - 1);

    // FRAC only documents the Q format; a format without integer bits is a configuration error.
    if (FRAC >= WIDTH || TIMESTEPS < 2 || NODES < 2) begin : g_param_check
        $error("fc2_output_decoder: illegal parameter combination");
    end

    dec_state_t               state;
    logic signed [ACC_W-1:0]  acc [0:NODES-1];
    logic [STEP_W-1:0]        step_cnt;
    logic [IDX_W-1:0]         scan_idx;
    logic [IDX_W-1:0]         best_idx;
    logic signed [ACC_W-1:0]  best;
    logic signed [ACC_W-1:0]  cand;
    logic signed [ACC_W-1:0]  seed;
    logic                     cand_wins;

    // The seed uses acc[0] including the final sample, since it lands on the same edge.
    always_comb begin
        cand      = acc[scan_idx];
        seed      = acc[0] + ACC_W'(fc_in[0]);
        cand_wins = (cand > best);
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            step_cnt    <= '0;
            scan_idx    <= '0;
            best_idx    <= '0;
            best        <= '0;
            class_id    <= '0;
            class_score <= '0;
            for (int i = 0; i < NODES; i++) begin
                acc[i] <= '0;
            end
        end else if (start) begin
            state    <= ACCUM;
            step_cnt <= '0;
            for (int i = 0; i < NODES; i++) begin
                acc[i] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        for (int i = 0; i < NODES; i++) begin
                            acc[i] <= acc[i] + ACC_W'(fc_in[i]);
                        end
                        step_cnt <= step_cnt + 1'b1;
                        if (step_cnt == LAST_STEP) begin
                            state    <= SCAN;
                            scan_idx <= '0;
                            best     <= seed;
                            best_idx <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (cand_wins) begin
                        best     <= cand;
                        best_idx <= scan_idx;
                    end
                    // The last comparison is folded straight into the published result.
                    if (scan_idx == LAST_IDX) begin
                        state       <= DONE;
                        class_id    <= cand_wins ? scan_idx : best_idx;
                        class_score <= cand_wins ? cand : best;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fc2_output_decoder.md
FC2_OUTPUT_DECODER -- requirements
Module: fc2_output_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 24: width of each FC2 output, Q7.17 signed.
REQ-002 SHALL have parameter FRAC, default 17: fractional bits; informational, no rescaling performed.
REQ-003 SHALL have parameter NODES, default 10: number of FC2 output neurons.
REQ-004 SHALL have parameter TIMESTEPS, default 8: SNN timesteps per frame, >= 2.
REQ-005 SHALL have derived localparam ACC_W = WIDTH + $clog2(TIMESTEPS): accumulator width.
REQ-006 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  one-cycle pulse that begins a new frame.
REQ-009 SHALL have port in_valid  input  1  fc_in carries one timestep's FC2 results this cycle.
REQ-010 SHALL have port fc_in  input  signed [WIDTH-1:0] x [0:NODES-1]  per-neuron FC2 outputs.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse: class_id and class_score are newly valid.
REQ-013 SHALL have port class_id  output  [$clog2(NODES)-1:0]  index of the winning neuron.
REQ-014 SHALL have port class_score  output  signed [ACC_W-1:0]  accumulated value of the winner.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM, SCAN, DONE.
REQ-016 IDLE: start -> clear all NODES accumulators and step counter; next state ACCUM.
REQ-017 ACCUM: each in_valid cycle -> acc[i] += sign-extended fc_in[i] for all i, in parallel; step counter increments.
REQ-018 ACCUM: gaps in in_valid are permitted; state holds and accumulators hold.
REQ-019 ACCUM: the in_valid that brings step count to TIMESTEPS -> next state SCAN; scan index = 0; best = acc[0] seed.
REQ-020 SCAN: one neuron per cycle, index 0..NODES-1; replace best when acc[idx] > best (strict), so ties resolve to the lowest index; SCAN lasts exactly NODES cycles.
REQ-021 DONE: lasts one cycle; done = 1; class_id/class_score are registered this cycle; next state IDLE.
REQ-022 Latency: last in_valid accepted at edge k -> done high during cycle k+NODES+1.
REQ-023 class_id and class_score SHALL hold their values until the next done.
REQ-024 start in ACCUM, SCAN or DONE SHALL abort the frame: accumulators cleared, state ACCUM, no done pulse for the aborted frame.
REQ-025 start and in_valid in the same cycle: start wins; the sample is discarded.
REQ-026 in_valid in IDLE, SCAN or DONE SHALL be ignored.
REQ-027 Accumulation SHALL be exact two's-complement with no saturation; ACC_W guarantees no overflow.

Reset
REQ-028 reset low SHALL asynchronously force state IDLE, and set busy=0, done=0, class_id=0, class_score=0, accumulators 0, counters 0.
REQ-029 Reset during ACCUM or SCAN SHALL discard the frame; no done follows reset release.

Structure
REQ-030 The shared package snn_pkg SHALL hold the WIDTH/FRAC defaults and the decoder state enum typedef.
REQ-031 The block SHALL be flat; no sub-module (the compare-and-select is a single inline registered comparator).

Verification
REQ-032 Reset: hold reset low mid-ACCUM -> busy=0, done=0, class_id=0, class_score=0 immediately, without waiting for a clock edge.
REQ-033 Start, then 8 in_valid with fc_in[3]=0x020000 (1.0) and all others 0 -> done 11 cycles after the last valid; class_id=3; class_score=1048576 (8.0).
REQ-034 Tie: fc_in[2]=fc_in[7]=0x010000 (0.5) for all 8 steps, others 0 -> class_id=2; class_score=524288.
REQ-035 All negative: fc_in[i]=-(i+1)*1.0 for 8 steps -> class_id=0; class_score=-1048576; extremes: fc_in[9]=0x7FFFFF for 8 steps -> class_id=9; class_score=67108856, no wrap.
REQ-036 Gappy in_valid with 3 idle cycles between steps -> result identical to REQ-033; start after the 3rd step -> no done, fresh 8-step frame required.
REQ-037 start coincident with in_valid, and in_valid during SCAN -> sample ignored; result unchanged versus the reference frame.
